// File: rtl/fp32_pkg.sv
// fp32_pkg: binary32 field layout, constants and operand classification
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;
  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fp_class_e;
  // Subnormals have exp==0 and are deliberately classed as zero (flush-to-zero)
  function automatic fp_class_e fp_class(input fp32_t x);
    return x.exp == '1 ? (x.frac != '0 ? NAN : INF) : x.exp == '0 ? ZERO : NORMAL;
  endfunction
endpackage

// File: rtl/fp32_lzc.sv
// fp32_lzc: 27-bit leading-zero counter for post-add normalization
module fp32_lzc (
  input  logic [26:0] x,
  output logic [4:0]  cnt
);
  // Scan upward so the highest set bit is the last one to set the count
  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < 27; i++)
      if (x[i]) cnt = 5'(26 - i);
  end
endmodule

// File: rtl/fp32_add_reg.sv
// fp32_add_reg: registered binary32 adder, RNE, FTZ; FP32_ADD_REG_FLAGS_EN adds {invalid,overflow,underflow,inexact}
module fp32_add_reg
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [31:0] s
`ifdef FP32_ADD_REG_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);
  fp32_t ua, ub, big, sml;
  fp_class_e ca, cb;
  logic a_gt, inc, of, uf, nan_in, inf_clash, norm_path;
  logic [7:0] d;
  logic [51:0] sh;
  logic [26:0] big_al, sml_al, norm;
  logic [27:0] sum;
  logic [4:0] lz;
  logic signed [9:0] e_norm, e_rnd;
  logic [24:0] rnd;
  logic [31:0] sum_res, res, s_d, s_q;
  logic out_valid_d, out_valid_q;

  fp32_lzc u_lzc (.x(sum[26:0]), .cnt(lz));

  // Classify, align, add, normalize, round, then overlay the special cases
  always_comb begin
    ua = a;
    ub = b;
    ca = fp_class(ua);
    cb = fp_class(ub);
    a_gt = ua[30:0] >= ub[30:0];
    big = a_gt ? ua : ub;
    sml = a_gt ? ub : ua;
    d = big.exp - sml.exp;
    sh = {1'b1, sml.frac, 28'b0} >> d;
    sml_al = d >= 8'd26 ? 27'd1 : {sh[51:26], |sh[25:0]};
    big_al = {1'b1, big.frac, 3'b0};
    sum = ua.sign ^ ub.sign ? {1'b0, big_al} - {1'b0, sml_al} : {1'b0, big_al} + {1'b0, sml_al};
    norm = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << lz;
    e_norm = sum[27] ? $signed({2'b0, big.exp}) + 10'sd1 : $signed({2'b0, big.exp}) - $signed({5'b0, lz});
    inc = norm[2] & (|norm[1:0] | norm[3]);
    rnd = {1'b0, norm[26:3]} + {24'b0, inc};
    e_rnd = e_norm + $signed({9'b0, rnd[24]});
    of = sum != '0 && e_rnd >= 10'sd255;
    uf = sum != '0 && e_rnd <= 10'sd0;
    sum_res = sum == '0 ? 32'h0 : of ? {big.sign, POS_INF[30:0]} : uf ? {big.sign, 31'b0} :
              {big.sign, e_rnd[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
    nan_in = ca == NAN || cb == NAN;
    inf_clash = ca == INF && cb == INF && ua.sign != ub.sign;
    norm_path = ca == NORMAL && cb == NORMAL;
    res = nan_in || inf_clash ? QNAN : ca == INF ? a : cb == INF ? b :
          ca == ZERO && cb == ZERO ? {a[31] & b[31], 31'b0} : ca == ZERO ? b : cb == ZERO ? a : sum_res;
  end

`ifdef FP32_ADD_REG_FLAGS_EN
  logic [3:0] flags_d, flags_q;
  // Exception flags share the result's load enable
  always_comb begin
    flags_d = in_valid ? {nan_in | inf_clash, norm_path & of, norm_path & uf,
                          norm_path & sum != '0 & (norm[2] | (|norm[1:0]) | of | uf)} : flags_q;
  end
  // Flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else flags_q <= flags_d;
  end
  assign flags = flags_q;
`else
  logic unused_flags;
  assign unused_flags = norm_path;
`endif

  // Load the result only on valid input; valid tracks input with one cycle delay
  always_comb begin
    s_d = in_valid ? res : s_q;
    out_valid_d = in_valid;
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      s_q <= s_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s = s_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_fp32_add_reg.sv
// tb_fp32_add_reg: scoreboard bench for fp32_add_reg against a real-arithmetic reference model
module tb_fp32_add_reg;
  import fp32_pkg::*;
  logic clk, rst_n, in_valid, out_valid;
  logic [31:0] a, b, s, x, y, last;
  logic [35:0] tmp, e;
  logic [95:0] dir [18];
  logic [35:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  int k;
`ifdef FP32_ADD_REG_FLAGS_EN
  logic [3:0] flags;
`endif

  fp32_add_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .s(s)
`ifdef FP32_ADD_REG_FLAGS_EN
    , .flags(flags)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic real pow2(input int p);
    real r = 1.0;
    for (int i = 0; i < (p < 0 ? -p : p); i++) r = p < 0 ? r / 2.0 : r * 2.0;
    return r;
  endfunction

  function automatic real val(input logic [31:0] v);
    real m = (1.0 + real'(v[22:0]) / 8388608.0) * pow2(int'(v[30:23]) - BIAS);
    return v[31] ? -m : m;
  endfunction

  // Reference: exact real sum, rounded to 24 significant bits with ties-to-even
  function automatic logic [35:0] model(input logic [31:0] p, input logic [31:0] q);
    bit np, nq, ip, iq, zp, zq, sg;
    real v, m, fl;
    int ex, fi;
    np = p[30:23] == 8'hFF && p[22:0] != 0;
    nq = q[30:23] == 8'hFF && q[22:0] != 0;
    ip = p[30:23] == 8'hFF && p[22:0] == 0;
    iq = q[30:23] == 8'hFF && q[22:0] == 0;
    zp = p[30:23] == 0;
    zq = q[30:23] == 0;
    if (np || nq || (ip && iq && p[31] != q[31])) return {4'b1000, QNAN};
    if (ip) return {4'b0, p};
    if (iq) return {4'b0, q};
    if (zp && zq) return {4'b0, p[31] & q[31], 31'b0};
    if (zp) return {4'b0, q};
    if (zq) return {4'b0, p};
    v = val(p) + val(q);
    if (v == 0.0) return 36'h0;
    sg = v < 0.0;
    m = sg ? -v : v;
    ex = 0;
    while (m >= 2.0) begin m = m / 2.0; ex++; end
    while (m < 1.0) begin m = m * 2.0; ex--; end
    m = m * 8388608.0;
    fl = $floor(m);
    fi = $rtoi(fl);
    if (m - fl > 0.5 || (m - fl == 0.5 && fi % 2 == 1)) fi++;
    if (fi == 16777216) begin fi = 8388608; ex++; end
    if (ex + BIAS >= 255) return {4'b0101, sg, 8'hFF, 23'b0};
    if (ex + BIAS <= 0) return {4'b0011, sg, 31'b0};
    return {3'b0, m != fl, sg, 8'(ex + BIAS), 23'(fi - 8388608)};
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", n, act, req);
    end
  endtask

  task automatic send(input logic [31:0] p, input logic [31:0] q, input logic [35:0] ex);
    a = p;
    b = q;
    in_valid = 1;
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  // Monitor: pop and compare on every presented result, otherwise s must hold
  always @(negedge clk) begin
    if (!rst_n) last = 0;
    else if (out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_output", s, 32'hx);
      else begin
        e = exp_q.pop_front();
        chk($sformatf("sum %h+%h", a, b), s, e[31:0]);
`ifdef FP32_ADD_REG_FLAGS_EN
        chk("flags", {28'b0, flags}, {28'b0, e[35:32]});
`endif
        last = s;
      end
    end else chk("hold", s, last);
  end

  initial begin
    dir = '{
      96'h3F800000_3F800000_40000000, 96'h3F800000_BF800000_00000000,
      96'h00000000_80000000_00000000, 96'h80000000_80000000_80000000,
      96'h3F000000_BF800000_BF000000, 96'h3E4CCCCD_3DCCCCCD_3E99999A,
      96'h3EAAAAAB_3F2AAAAB_3F800000, 96'h3F800000_BE000000_3F600000,
      96'h44610000_42C80000_447A0000, 96'h4479C000_BF800000_44798000,
      96'h7F7FFFFF_7F7FFFFF_7F800000, 96'h7F800000_7F800000_7F800000,
      96'hFF800000_FF800000_FF800000, 96'h7F800000_FF800000_7FC00000,
      96'h7FC00001_00000000_7FC00000, 96'h7F812345_3F800000_7FC00000,
      96'h7FC00000_FFFFFFFF_7FC00000, 96'h7FA00000_7F800000_7FC00000};
    rst_n = 0;
    in_valid = 0;
    a = 0;
    b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_s", s, 32'h0);
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1;
    for (int i = 0; i < 18; i++) begin
      tmp = model(dir[i][95:64], dir[i][63:32]);
      send(dir[i][95:64], dir[i][63:32], {tmp[35:32], dir[i][31:0]});
    end
    for (int i = 0; i < 3000; i++) begin
      x = $urandom;
      y = $urandom;
      k = $urandom_range(7);
      case (k)
        0: y = x ^ 32'h80000000 ^ 32'($urandom_range(3));
        1, 2, 3: y[30:23] = x[30:23] + 8'($urandom_range(30)) - 8'd15;
        4: begin x[30:23] = 8'hFF; if ($urandom_range(1) == 1) x[22:0] = 0; end
        5: y[30:23] = 0;
        6: begin x[30:23] = 8'hFE; y[30:23] = 8'hFE - 8'($urandom_range(2)); end
        default: ;
      endcase
      send(x, y, model(x, y));
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    send(32'h3F800000, 32'h3F800000, model(32'h3F800000, 32'h3F800000));
    @(negedge clk);
    @(negedge clk);
    chk("drain", exp_q.size(), 0);
    #2;
    rst_n = 0;
    #1;
    chk("async_reset_s", s, 32'h0);
    chk("async_reset_valid", {31'b0, out_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk("held_reset_s", s, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
